// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM for the multi-cycle RV32I datapath. It sequences the
// fetch, decode, execute, memory and write-back steps, and runs the req/ack
// handshake with the unified instruction/data memory. It also counts retired
// instructions and halts on ECALL, an illegal opcode or a memory timeout.
// Control outputs are decoded combinationally from the state and opcode, so
// they are valid in the same cycle as the state they belong to.
module multicycle_control #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [6:0]           opcode,
  input  logic                 alu_bcond,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic [1:0]           err,
  output logic [CNT_WIDTH-1:0] instr_count
);

  // The wait counter only has to reach TIMEOUT-1 before the timeout fires,
  // so $clog2(TIMEOUT) bits are enough.
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_ECALL  = 7'b1110011
  } opcode_t;

  state_t                r_state;
  err_t                  r_err;
  logic [WAIT_W-1:0]     r_wait;
  logic [CNT_WIDTH-1:0]  r_count;

  logic w_is_r;
  logic w_is_i;
  logic w_is_ld;
  logic w_is_st;
  logic w_is_br;
  logic w_is_ecall;
  logic w_legal;
  logic w_mem_phase;
  logic w_mem_wait;
  logic w_timeout;
  logic w_retire;

  // Opcode decode from the instruction register.
  always_comb begin
    w_is_r     = (opcode == OP_R);
    w_is_i     = (opcode == OP_I);
    w_is_ld    = (opcode == OP_LOAD);
    w_is_st    = (opcode == OP_STORE);
    w_is_br    = (opcode == OP_BRANCH);
    w_is_ecall = (opcode == OP_ECALL);
    w_legal    = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br | w_is_ecall;
  end

  // Handshake status, timeout detection and retirement strobe.
  always_comb begin
    w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
    w_mem_wait  = w_mem_phase && !mem_ack;
    // An ack in the cycle the counter hits its limit wins: w_mem_wait is 0.
    w_timeout   = TIMEOUT_EN && w_mem_wait && (r_wait == WAIT_LAST);
    w_retire    = ((r_state == S_EX)  && w_is_br) ||
                  ((r_state == S_MEM) && mem_ack && w_is_st) ||
                  (r_state == S_WB);
  end

  // Main sequencing FSM with the sticky halt error code.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IF;
      r_err   <= ERR_NONE;
    end else if (w_timeout) begin
      r_state <= S_HALT;
      r_err   <= ERR_TIMEOUT;
    end else begin
      case (r_state)
        S_IF: begin
          if (mem_ack) begin
            r_state <= S_ID;
          end
        end
        S_ID: begin
          if (w_is_ecall) begin
            r_state <= S_HALT;
            r_err   <= ERR_NONE;
          end else if (!w_legal) begin
            r_state <= S_HALT;
            r_err   <= ERR_ILLEGAL;
          end else begin
            r_state <= S_EX;
          end
        end
        S_EX: begin
          if (w_is_ld || w_is_st) begin
            r_state <= S_MEM;
          end else if (w_is_br) begin
            r_state <= S_IF;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_state <= w_is_st ? S_IF : S_WB;
          end
        end
        S_WB: begin
          r_state <= S_IF;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_HALT;
        end
      endcase
    end
  end

  // Memory wait counter: counts unacknowledged request cycles. Clearing it
  // whenever the FSM is not waiting covers entry into IF/MEM and every ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait <= '0;
    end else if (w_mem_wait && !w_timeout) begin
      r_wait <= r_wait + WAIT_W'(1);
    end else begin
      r_wait <= '0;
    end
  end

  // Retired-instruction counter, wrapping at its width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_retire && !w_timeout) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  // Control outputs decoded from the current state and opcode.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (r_state)
      S_IF: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_ID: begin
        // PC + imm goes to ALUOut as the speculative branch target.
        alu_src_b = 2'b10;
      end
      S_EX: begin
        alu_src_a = 1'b1;
        if (w_is_r) begin
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
        end else if (w_is_i) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end else if (w_is_ld || w_is_st) begin
          alu_src_b = 2'b10;
          alu_op    = 2'b00;
        end else if (w_is_br) begin
          alu_src_b = 2'b00;
          alu_op    = 2'b01;
          pc_write  = alu_bcond;
          pc_src    = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = w_is_st;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_ld;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign err         = r_err;
  assign instr_count = r_count;

endmodule
